// File: rtl/risc_spm_core.sv
// Parametrised RISC SPM core: register file, ALU, flags and a fetch/execute FSM
// that talks to external memory over a variable-latency req/ack handshake.
module risc_spm_core #(
    parameter int          word_size = 8,
    parameter int          REG_SEL   = 2,
    parameter int          ADDR_W    = 8,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [word_size-1:0] mem_wdata,
    input  logic [word_size-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted,
    output logic                 illegal_op
);
    localparam int NUM_REGS = 2 ** REG_SEL;

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                           OP_NOT = 4'h4, OP_RD  = 4'h5, OP_WR  = 4'h6, OP_BR  = 4'h7,
                           OP_BRZ = 4'h8, OP_BRV = 4'h9, OP_MUL = 4'hA, OP_HLT = 4'hF;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_ADDR, S_MEM, S_HALT} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [word_size-1:0]   ir_q, ir_d;
    logic [word_size-1:0]   ar_q, ar_d;
    logic [word_size-1:0]   regs_q [NUM_REGS];
    logic [word_size-1:0]   regs_d [NUM_REGS];
    logic                   zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d;

    logic [3:0]             op;
    logic [REG_SEL-1:0]     src, dst;
    logic [word_size-1:0]   rs_val, rd_val, alu_res;
    logic [word_size:0]     sum_w, diff_w;
    logic [2*word_size-1:0] prod_w;
    logic                   alu_ovf;

    assign op     = ir_q[word_size-1 -: 4];
    assign src    = ir_q[word_size-5 -: REG_SEL];
    assign dst    = ir_q[word_size-5-REG_SEL -: REG_SEL];
    assign rs_val = regs_q[src];
    assign rd_val = regs_q[dst];
    // The extra top bit of sum/diff is the carry-out / borrow (d < s unsigned)
    assign sum_w  = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff_w = {1'b0, rd_val} - {1'b0, rs_val};
    assign prod_w = {{word_size{1'b0}}, rd_val} * {{word_size{1'b0}}, rs_val};

    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = sum_w[word_size-1:0];  alu_ovf = sum_w[word_size];  end
            OP_SUB:  begin alu_res = diff_w[word_size-1:0]; alu_ovf = diff_w[word_size]; end
            OP_AND:  alu_res = rd_val & rs_val;
            OP_NOT:  alu_res = ~rs_val;
            OP_MUL:  begin
                alu_res = prod_w[word_size-1:0];
                alu_ovf = |prod_w[2*word_size-1:word_size];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ar_d      = ar_q;
        regs_d    = regs_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_NOP: state_d = S_FETCH;
                    OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_MUL: begin
                        regs_d[dst] = alu_res;
                        zero_d      = (alu_res == '0);
                        ovf_d       = alu_ovf;
                        state_d     = S_FETCH;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ, OP_BRV: state_d = S_ADDR;
                    OP_HLT: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_ADDR: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_d = pc_q + ADDR_W'(1);
                    ar_d = mem_rdata;
                    if ((op == OP_BR) || (op == OP_BRZ && zero_q) || (op == OP_BRV && ovf_q))
                        pc_d = mem_rdata[ADDR_W-1:0];
                    state_d = (op == OP_RD || op == OP_WR) ? S_MEM : S_FETCH;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = ar_q[ADDR_W-1:0];
                mem_we   = (op == OP_WR);
                if (op == OP_WR) mem_wdata = rs_val;
                if (mem_ack) begin
                    if (op == OP_RD) regs_d[dst] = mem_rdata;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Reset must kill an in-flight request immediately, not at the next edge
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= '0;
            ar_q      <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ar_q      <= ar_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end
endmodule

// File: tb/tb_risc_spm_core.sv
// Bench for risc_spm_core: memory model with programmable ack latency; expected
// memory writes are queued per program and compared as the core issues them.
module tb_risc_spm_core;
    localparam int W  = 8;
    localparam int RS = 2;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr, pc;
    logic [W-1:0]  mem_wdata, mem_rdata;
    logic          halted, illegal_op;

    logic [W-1:0]  mem [0:255];
    int            lat = 0;
    int            wcnt = 0;
    int            checks = 0;
    int            errors = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    risc_spm_core #(.word_size(W), .REG_SEL(RS), .ADDR_W(AW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
        .halted(halted), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (!halted && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_halted"}, halted, 1);
    endtask

    // Memory responder: acks after `lat` wait cycles, checks the request stays
    // stable while waiting, and pops the scoreboard on every write transfer.
    initial begin
        logic       pend;
        logic       pw;
        logic [7:0] pa, pd;
        wr_t        e;
        pend = 1'b0; pw = 1'b0; pa = '0; pd = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pend && !rst) begin
                check("hold_req", mem_req, 1);
                check("hold_addr", mem_addr, pa);
                check("hold_we", mem_we, pw);
                if (pw) check("hold_wdata", mem_wdata, pd);
            end
            pend = 1'b0;
            if (!mem_req) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= lat) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_write: observed addr %0h data %0h expected none",
                               mem_addr, mem_wdata);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                    end
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
                pend = 1'b1;
                pa = mem_addr;
                pw = mem_we;
                pd = mem_wdata;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);

        // RD R0,0x10 ; WR R0,0x80 ; HALT  (zero-wait)
        clear_mem();
        lat = 0;
        mem[8'h00] = 8'h50; mem[8'h01] = 8'h10;
        mem[8'h02] = 8'h60; mem[8'h03] = 8'h80;
        mem[8'h04] = 8'hF0; mem[8'h10] = 8'h05;
        exp_q.push_back('{addr: 8'h80, data: 8'h05});
        release_rst();
        repeat (3) @(posedge clk);
        #1;
        check("rd_mem_addr", mem_addr, 8'h10);
        check("rd_mem_we", mem_we, 0);
        @(posedge clk);
        #1;
        check("rd_pc_4clk", pc, 2);
        check("rd_next_fetch", mem_addr, 2);
        run_to_halt("t1");
        check("t1_pc", pc, 5);
        check("t1_illegal", illegal_op, 0);
        check("t1_sb_empty", exp_q.size(), 0);

        // ALU, flags and branch program
        rst = 1'b1;
        clear_mem();
        lat = 0;
        mem[8'h00] = 8'h50; mem[8'h01] = 8'h20;   // RD R0,0x20
        mem[8'h02] = 8'h51; mem[8'h03] = 8'h21;   // RD R1,0x21
        mem[8'h04] = 8'h14;                       // ADD R1->R0
        mem[8'h05] = 8'h90; mem[8'h06] = 8'h0A;   // BRV 0x0A (taken)
        mem[8'h07] = 8'hF0;
        mem[8'h0A] = 8'h60; mem[8'h0B] = 8'h80;   // WR R0,0x80
        mem[8'h0C] = 8'h80; mem[8'h0D] = 8'h30;   // BRZ 0x30 (not taken)
        mem[8'h0E] = 8'h20;                       // SUB R0->R0
        mem[8'h0F] = 8'h90; mem[8'h10] = 8'h30;   // BRV 0x30 (not taken)
        mem[8'h11] = 8'h80; mem[8'h12] = 8'h40;   // BRZ 0x40 (taken)
        mem[8'h13] = 8'hF0;
        mem[8'h20] = 8'hF0; mem[8'h21] = 8'h20;
        mem[8'h30] = 8'hF0;
        mem[8'h40] = 8'h60; mem[8'h41] = 8'h81;   // WR R0,0x81
        mem[8'h42] = 8'h46;                       // NOT R1->R2
        mem[8'h43] = 8'h68; mem[8'h44] = 8'h82;   // WR R2,0x82
        mem[8'h45] = 8'h36;                       // AND R1->R2
        mem[8'h46] = 8'h80; mem[8'h47] = 8'h50;   // BRZ 0x50 (taken)
        mem[8'h48] = 8'hF0;
        mem[8'h50] = 8'h15;                       // ADD R1,R1
        mem[8'h51] = 8'h64; mem[8'h52] = 8'h83;   // WR R1,0x83
        mem[8'h53] = 8'hF0;
        exp_q.push_back('{addr: 8'h80, data: 8'h10});
        exp_q.push_back('{addr: 8'h81, data: 8'h00});
        exp_q.push_back('{addr: 8'h82, data: 8'hDF});
        exp_q.push_back('{addr: 8'h83, data: 8'h40});
        release_rst();
        run_to_halt("t2");
        check("t2_pc", pc, 8'h54);
        check("t2_illegal", illegal_op, 0);
        check("t2_sb_empty", exp_q.size(), 0);

        // Delayed ack (3 wait cycles), MUL overflow feeding BRV
        rst = 1'b1;
        clear_mem();
        lat = 3;
        mem[8'h00] = 8'h52; mem[8'h01] = 8'h20;   // RD R2,0x20
        mem[8'h02] = 8'h53; mem[8'h03] = 8'h20;   // RD R3,0x20
        mem[8'h04] = 8'hAE;                       // MUL R3->R2
        mem[8'h05] = 8'h90; mem[8'h06] = 8'h30;   // BRV 0x30 (taken)
        mem[8'h07] = 8'hF0;
        mem[8'h20] = 8'h10;
        mem[8'h30] = 8'h68; mem[8'h31] = 8'h84;   // WR R2,0x84
        mem[8'h32] = 8'hF0;
        exp_q.push_back('{addr: 8'h84, data: 8'h00});
        release_rst();
        repeat (3) @(posedge clk);
        #1;
        check("wait_pc", pc, 0);
        check("wait_req", mem_req, 1);
        check("wait_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        check("ack_pc", pc, 1);
        run_to_halt("t3");
        check("t3_pc", pc, 8'h33);
        check("t3_sb_empty", exp_q.size(), 0);

        // Illegal opcode 0xC
        rst = 1'b1;
        clear_mem();
        lat = 1;
        mem[8'h00] = 8'h00; mem[8'h01] = 8'hC0;
        release_rst();
        run_to_halt("t4");
        check("t4_illegal", illegal_op, 1);
        check("t4_pc", pc, 2);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_req", mem_req, 0);
        check("t4_still_halted", halted, 1);

        // Reset asserted mid-write while ack is pending
        rst = 1'b1;
        clear_mem();
        lat = 2;
        mem[8'h00] = 8'h51; mem[8'h01] = 8'h20;   // RD R1,0x20
        mem[8'h02] = 8'h64; mem[8'h03] = 8'h90;   // WR R1,0x90
        mem[8'h20] = 8'h77;
        release_rst();
        begin
            int n = 0;
            while (!mem_we && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("t5_reach_wr", mem_we, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_req_drop", mem_req, 0);
        check("t5_we_drop", mem_we, 0);
        check("t5_pc", pc, 0);
        check("t5_illegal_clr", illegal_op, 0);
        mem[8'h00] = 8'h64; mem[8'h01] = 8'h91;   // WR R1,0x91
        mem[8'h02] = 8'hF0;
        lat = 0;
        exp_q.push_back('{addr: 8'h91, data: 8'h00});
        release_rst();
        run_to_halt("t5");
        check("t5_pc_end", pc, 3);
        check("t5_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
